// File: rtl/battle_pkg.sv
// battle_pkg: shared state encoding, move power table and cursor constants for the battle engine
package battle_pkg;
  typedef enum logic [3:0] {
    IDLE, PICK, MENU, MOVES, P_ATK, E_WAIT, E_ATK, WIN_WAIT, LOSE_WAIT, DONE
  } state_t;
  // Index 0 is the rightmost entry: powers 20,15,30,10,25,12,18,40 for moves 0..7
  localparam logic [7:0][7:0] MOVE_POWER = {8'd40, 8'd18, 8'd12, 8'd25, 8'd10, 8'd30, 8'd15, 8'd20};
  localparam logic CURSOR_FIGHT = 1'b0;
  localparam logic CURSOR_RUN = 1'b1;
endpackage

// File: rtl/sat_sub.sv
// sat_sub: unsigned subtract floored at zero
module sat_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a > b ? a - b : '0;
endmodule

// File: rtl/battle_engine.sv
// battle_engine: turn-based battle controller (menu, move select, damage, enemy turn, outcome)
module battle_engine
  import battle_pkg::*;
#(
  parameter int HP_W = 8,
  parameter int MAX_HP = 100,
  parameter int NUM_MOVES = 4,
  parameter int ENEMY_DMG = 10,
  parameter int ENEMY_FRAMES = 20,
  parameter int END_FRAMES = 15,
  parameter int XP_GAIN = 50,
  parameter int NUM_ENEMIES = 15
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         frame_tick,
  input  logic                         start,
  input  logic                         left_in,
  input  logic                         right_in,
  input  logic                         up_in,
  input  logic                         down_in,
  input  logic                         select,
  input  logic [HP_W-1:0]              health_in,
  input  logic [HP_W-1:0]              xp_in,
  input  logic [7:0]                   rand_in,
  output logic                         rng_en,
  output logic [3:0]                   state_out,
  output logic                         cursor_out,
  output logic [$clog2(NUM_MOVES)-1:0] move_idx,
  output logic [3:0]                   enemy_sel,
  output logic [HP_W-1:0]              health_out,
  output logic [HP_W-1:0]              enemy_hp,
  output logic [HP_W-1:0]              xp_out,
  output logic                         won,
  output logic                         lost,
  output logic                         ran,
  output logic                         done_out
);
  localparam int MW = $clog2(NUM_MOVES);
  localparam int CW = $clog2((ENEMY_FRAMES > END_FRAMES ? ENEMY_FRAMES : END_FRAMES) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [MW-1:0] move_n, move_inc, move_dec;
  logic [3:0] enemy_sel_n;
  logic [HP_W-1:0] health_n, enemy_hp_n, xp_n, e_dmg, p_dmg, e_left, p_left;
  logic [HP_W:0] xp_sum;
  logic cursor_n, won_n, lost_n, ran_n, done_n, rng_n;
  logic unused_rand;
  assign unused_rand = ^rand_in[7:4];
  assign state_out = state;
  assign e_dmg = HP_W'(MOVE_POWER[3'(move_idx)]) + HP_W'(rand_in[1:0]);
  assign p_dmg = HP_W'(ENEMY_DMG) + HP_W'(rand_in[3:2]);
  assign xp_sum = {1'b0, xp_out} + (HP_W+1)'(XP_GAIN);
  assign move_inc = move_idx == MW'(NUM_MOVES - 1) ? '0 : move_idx + 1'b1;
  assign move_dec = move_idx == '0 ? MW'(NUM_MOVES - 1) : move_idx - 1'b1;
  sat_sub #(.W(HP_W)) u_enemy_sub (.a(enemy_hp), .b(e_dmg), .y(e_left));
  sat_sub #(.W(HP_W)) u_player_sub (.a(health_out), .b(p_dmg), .y(p_left));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cursor_n = cursor_out;
    move_n = move_idx;
    enemy_sel_n = enemy_sel;
    health_n = health_out;
    enemy_hp_n = enemy_hp;
    xp_n = xp_out;
    won_n = won;
    lost_n = lost;
    ran_n = ran;
    done_n = done_out;
    rng_n = rng_en;
    // Losing start mid-battle counts as fleeing; everything else is left as-is
    if (state != IDLE && state != DONE && !start) begin
      state_n = IDLE;
      ran_n = 1'b1;
      rng_n = 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n = PICK;
          health_n = health_in;
          enemy_hp_n = HP_W'(MAX_HP);
          xp_n = xp_in;
          {won_n, lost_n, ran_n, done_n} = '0;
          cursor_n = CURSOR_FIGHT;
          move_n = '0;
          rng_n = 1'b1;
        end
        PICK: if ({1'b0, rand_in[3:0]} < 5'(NUM_ENEMIES)) begin
          enemy_sel_n = rand_in[3:0];
          rng_n = 1'b0;
          cnt_n = '0;
          state_n = health_out == '0 ? LOSE_WAIT : MENU;
        end
        MENU: if (frame_tick) begin
          cursor_n = right_in ? CURSOR_RUN : left_in ? CURSOR_FIGHT : cursor_out;
          if (select && cursor_out == CURSOR_FIGHT) state_n = MOVES;
          if (select && cursor_out == CURSOR_RUN) begin
            state_n = DONE;
            ran_n = 1'b1;
            done_n = 1'b1;
            rng_n = 1'b1;
          end
        end
        MOVES: if (frame_tick) begin
          move_n = (down_in && !up_in) ? move_inc : (up_in && !down_in) ? move_dec : move_idx;
          state_n = select ? P_ATK : left_in ? MENU : MOVES;
        end
        P_ATK: if (frame_tick) begin
          enemy_hp_n = e_left;
          cnt_n = '0;
          state_n = e_left == '0 ? WIN_WAIT : E_WAIT;
        end
        E_WAIT: if (frame_tick) begin
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(ENEMY_FRAMES - 1)) state_n = E_ATK;
        end
        E_ATK: if (frame_tick) begin
          health_n = p_left;
          cnt_n = '0;
          state_n = p_left == '0 ? LOSE_WAIT : MENU;
        end
        WIN_WAIT, LOSE_WAIT: if (frame_tick) begin
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(END_FRAMES - 1)) begin
            state_n = DONE;
            done_n = 1'b1;
            rng_n = 1'b1;
            won_n = state == WIN_WAIT;
            lost_n = state == LOSE_WAIT;
            if (state == WIN_WAIT) xp_n = xp_sum[HP_W] ? '1 : xp_sum[HP_W-1:0];
          end
        end
        DONE: if (!start) begin
          state_n = IDLE;
          done_n = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      cursor_out <= CURSOR_FIGHT;
      move_idx <= '0;
      enemy_sel <= '0;
      health_out <= health_in;
      enemy_hp <= HP_W'(MAX_HP);
      xp_out <= xp_in;
      {won, lost, ran, done_out} <= '0;
      rng_en <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cursor_out <= cursor_n;
      move_idx <= move_n;
      enemy_sel <= enemy_sel_n;
      health_out <= health_n;
      enemy_hp <= enemy_hp_n;
      xp_out <= xp_n;
      won <= won_n;
      lost <= lost_n;
      ran <= ran_n;
      done_out <= done_n;
      rng_en <= rng_n;
    end
  end
endmodule
